// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for a block's lanes in lockstep.
// Optional cycle counter enabled by defining CORE_SCHED_PERF_CYCLES_EN.
module core_scheduler #(
   parameter int THREADS_PER_BLOCK = 4,
   parameter int PC_BITS           = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [7:0]                           block_id,
   input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
   input  logic                                 fetch_valid,
   input  logic                                 decoded_ret,
   input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
   input  logic [PC_BITS-1:0]                   next_pc,
   output logic [2:0]                           core_state,
   output logic [PC_BITS-1:0]                   current_pc,
   output logic [THREADS_PER_BLOCK-1:0]         thread_enable,
   output logic [7:0]                           block_id_q,
   output logic [15:0]                          perf_cycles,
   output logic                                 done
);

   localparam int unsigned CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_FETCH   = 3'b001,
      S_DECODE  = 3'b010,
      S_REQUEST = 3'b011,
      S_WAIT    = 3'b100,
      S_EXECUTE = 3'b101,
      S_UPDATE  = 3'b110,
      S_DONE    = 3'b111
   } state_t;

   state_t                         state;
   logic [CNT_W-1:0]               count_clamped_c;
   logic [THREADS_PER_BLOCK-1:0]   enable_c;
   logic                           lanes_busy_c;

   assign core_state = state;

   // Clamp the requested count to the lane count and expand it into a lane mask.
   always_comb begin
      count_clamped_c = thread_count;
      if (thread_count > CNT_W'(THREADS_PER_BLOCK))
         count_clamped_c = CNT_W'(THREADS_PER_BLOCK);
      enable_c = '0;
      for (int i = 0; i < THREADS_PER_BLOCK; i++)
         enable_c[i] = (CNT_W'(i) < count_clamped_c);
   end

   // A lane holds WAIT only while enabled and REQUESTING or WAITING.
   always_comb begin
      lanes_busy_c = 1'b0;
      for (int i = 0; i < THREADS_PER_BLOCK; i++)
         if (thread_enable[i] &&
             (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10))
            lanes_busy_c = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         current_pc    <= '0;
         thread_enable <= '0;
         block_id_q    <= '0;
         done          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  block_id_q    <= block_id;
                  thread_enable <= enable_c;
                  current_pc    <= '0;
                  if (count_clamped_c == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_FETCH;
                  end
               end
            end
            S_FETCH:   if (fetch_valid) state <= S_DECODE;
            S_DECODE:  state <= S_REQUEST;
            S_REQUEST: state <= S_WAIT;
            S_WAIT:    if (!lanes_busy_c) state <= S_EXECUTE;
            S_EXECUTE: state <= S_UPDATE;
            S_UPDATE: begin
               if (decoded_ret) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  current_pc <= next_pc;
                  state      <= S_FETCH;
               end
            end
            S_DONE:    state <= S_DONE;
            default:   state <= S_IDLE;
         endcase
      end
   end

`ifdef CORE_SCHED_PERF_CYCLES_EN
   logic [15:0] perf_q;

   // Counts active cycles of the current block, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= '0;
      end else if (state == S_IDLE) begin
         if (start) perf_q <= '0;
      end else if (state != S_DONE && perf_q != 16'hFFFF) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: start-vector table plus hand-written multi-cycle sequences.
module tb_core_scheduler;

   localparam int THREADS = 4;
   localparam int PCB     = 8;

   localparam logic [2:0] ST_IDLE = 3'b000, ST_FETCH = 3'b001, ST_DECODE = 3'b010,
                          ST_REQ  = 3'b011, ST_WAIT  = 3'b100, ST_EXEC   = 3'b101,
                          ST_UPD  = 3'b110, ST_DONE  = 3'b111;

`ifdef CORE_SCHED_PERF_CYCLES_EN
   localparam logic [15:0] EXP_PERF3 = 16'd24;
`else
   localparam logic [15:0] EXP_PERF3 = 16'd0;
`endif

   logic              clk;
   logic              reset;
   logic              start;
   logic [7:0]        block_id;
   logic [2:0]        thread_count;
   logic              fetch_valid;
   logic              decoded_ret;
   logic [7:0]        lsu_state;
   logic [PCB-1:0]    next_pc;
   logic [2:0]        core_state;
   logic [PCB-1:0]    current_pc;
   logic [THREADS-1:0] thread_enable;
   logic [7:0]        block_id_q;
   logic [15:0]       perf_cycles;
   logic              done;

   int checks   = 0;
   int failures = 0;

   core_scheduler #(.THREADS_PER_BLOCK(THREADS), .PC_BITS(PCB)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .block_id     (block_id),
      .thread_count (thread_count),
      .fetch_valid  (fetch_valid),
      .decoded_ret  (decoded_ret),
      .lsu_state    (lsu_state),
      .next_pc      (next_pc),
      .core_state   (core_state),
      .current_pc   (current_pc),
      .thread_enable(thread_enable),
      .block_id_q   (block_id_q),
      .perf_cycles  (perf_cycles),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       start;
      logic [7:0] bid;
      logic [2:0] cnt;
      logic [2:0] exp_state;
      logic [3:0] exp_en;
      logic [7:0] exp_bid;
      logic       exp_done;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      start        = 1'b0;
      block_id     = 8'h00;
      thread_count = 3'd0;
      fetch_valid  = 1'b0;
      decoded_ret  = 1'b0;
      lsu_state    = 8'h00;
      next_pc      = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic run_until(input logic [2:0] st, input string name);
      int n;
      n = 0;
      while (core_state != st && n < 200) begin
         tick();
         n++;
      end
      check({name, "_reached"}, 32'(core_state), 32'(st));
   endtask

   initial begin
      // start, block_id, count -> state/enable/block_id_q/done after one edge
      vecs[0] = '{1'b0, 8'h33, 3'd4, ST_IDLE,  4'b0000, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 8'hA1, 3'd0, ST_DONE,  4'b0000, 8'hA1, 1'b1};
      vecs[2] = '{1'b1, 8'h12, 3'd7, ST_FETCH, 4'b1111, 8'h12, 1'b0};
      vecs[3] = '{1'b1, 8'h02, 3'd1, ST_FETCH, 4'b0001, 8'h02, 1'b0};
      vecs[4] = '{1'b1, 8'hFE, 3'd2, ST_FETCH, 4'b0011, 8'hFE, 1'b0};
      vecs[5] = '{1'b1, 8'h40, 3'd5, ST_FETCH, 4'b1111, 8'h40, 1'b0};

      do_reset();
      check("rst_state", 32'(core_state), 32'(ST_IDLE));
      check("rst_pc", 32'(current_pc), 32'd0);
      check("rst_en", 32'(thread_enable), 32'd0);
      check("rst_bid", 32'(block_id_q), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_perf", 32'(perf_cycles), 32'd0);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         start        = vecs[v].start;
         block_id     = vecs[v].bid;
         thread_count = vecs[v].cnt;
         tick();
         check($sformatf("vec%0d_state", v), 32'(core_state), 32'(vecs[v].exp_state));
         check($sformatf("vec%0d_en", v), 32'(thread_enable), 32'(vecs[v].exp_en));
         check($sformatf("vec%0d_bid", v), 32'(block_id_q), 32'(vecs[v].exp_bid));
         check($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      end

      // Single RET instruction: full state walk, done on the 7th edge
      begin
         logic [2:0] seq[7];
         seq = '{ST_FETCH, ST_DECODE, ST_REQ, ST_WAIT, ST_EXEC, ST_UPD, ST_DONE};
         do_reset();
         start = 1'b1; block_id = 8'h05; thread_count = 3'd4;
         fetch_valid = 1'b1; decoded_ret = 1'b1; lsu_state = 8'h00;
         for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("walk_state%0d", i), 32'(core_state), 32'(seq[i]));
            check($sformatf("walk_done%0d", i), 32'(done), (i == 6) ? 32'd1 : 32'd0);
         end
         check("walk_bid", 32'(block_id_q), 32'h05);
         check("walk_en", 32'(thread_enable), 32'hF);
         check("walk_pc", 32'(current_pc), 32'd0);
         start = 1'b0;
         tick(); tick();
         check("done_hold_state", 32'(core_state), 32'(ST_DONE));
         check("done_hold_done", 32'(done), 32'd1);
      end

      // Disabled lane 3 busy must not hold WAIT
      begin
         int n;
         do_reset();
         start = 1'b1; thread_count = 3'd3; fetch_valid = 1'b1;
         lsu_state = 8'b10_00_00_00;
         tick();
         run_until(ST_WAIT, "mask_wait");
         n = 0;
         while (core_state == ST_WAIT && n < 50) begin
            tick();
            n++;
         end
         check("mask_dwell", 32'(n), 32'd1);
         check("mask_exec", 32'(core_state), 32'(ST_EXEC));
         check("mask_en", 32'(thread_enable), 32'h7);
      end

      // Lane 1 busy: 01 during REQUEST and WAIT1, 10 for WAIT2..4, 11 at WAIT5
      begin
         logic [1:0] lane1[6];
         int waits;
         lane1 = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11};
         do_reset();
         start = 1'b1; thread_count = 3'd4; fetch_valid = 1'b1;
         tick();
         run_until(ST_REQ, "dwell_req");
         waits = 0;
         for (int k = 0; k < 6; k++) begin
            lsu_state = {4'b0000, lane1[k], 2'b00};
            check($sformatf("dwell_state%0d", k), 32'(core_state),
                  (k == 0) ? 32'(ST_REQ) : 32'(ST_WAIT));
            if (core_state == ST_WAIT) waits++;
            tick();
         end
         check("dwell_count", 32'(waits), 32'd5);
         check("dwell_exec", 32'(core_state), 32'(ST_EXEC));
      end

      // Three instructions, fetch delayed 2 cycles, RET on the third
      begin
         do_reset();
         start = 1'b1; thread_count = 3'd4; block_id = 8'h09;
         fetch_valid = 1'b0; decoded_ret = 1'b0;
         tick();
         for (int j = 0; j < 3; j++) begin
            check($sformatf("pc_ins%0d", j), 32'(current_pc), 32'(j));
            check($sformatf("fetch_ins%0d", j), 32'(core_state), 32'(ST_FETCH));
            tick();
            tick();
            check($sformatf("fetch_hold%0d", j), 32'(core_state), 32'(ST_FETCH));
            fetch_valid = 1'b1;
            tick();
            fetch_valid = 1'b0;
            check($sformatf("decode_ins%0d", j), 32'(core_state), 32'(ST_DECODE));
            tick(); tick(); tick();
            check($sformatf("exec_ins%0d", j), 32'(core_state), 32'(ST_EXEC));
            decoded_ret = (j == 2);
            next_pc     = PCB'(j + 1);
            tick();
            check($sformatf("upd_ins%0d", j), 32'(core_state), 32'(ST_UPD));
            tick();
         end
         check("multi_state", 32'(core_state), 32'(ST_DONE));
         check("multi_done", 32'(done), 32'd1);
         check("multi_pc", 32'(current_pc), 32'd2);
         check("multi_perf", 32'(perf_cycles), 32'(EXP_PERF3));
         tick();
         check("multi_perf_hold", 32'(perf_cycles), 32'(EXP_PERF3));
      end

      // Reset while in WAIT with current_pc=3, then a fresh block
      begin
         do_reset();
         start = 1'b1; thread_count = 3'd4; fetch_valid = 1'b1;
         decoded_ret = 1'b0; next_pc = 8'd3;
         tick();
         run_until(ST_UPD, "mid_upd");
         lsu_state = 8'b00_00_00_10;
         tick();
         run_until(ST_WAIT, "mid_wait");
         check("mid_pc3", 32'(current_pc), 32'd3);
         tick();
         check("mid_stuck", 32'(core_state), 32'(ST_WAIT));
         reset = 1'b1;
         tick();
         check("mid_rst_state", 32'(core_state), 32'(ST_IDLE));
         check("mid_rst_pc", 32'(current_pc), 32'd0);
         check("mid_rst_done", 32'(done), 32'd0);
         check("mid_rst_en", 32'(thread_enable), 32'd0);
         check("mid_rst_perf", 32'(perf_cycles), 32'd0);
         reset = 1'b0; start = 1'b0; lsu_state = 8'h00;
         tick();
         start = 1'b1; thread_count = 3'd2; block_id = 8'h77; decoded_ret = 1'b1;
         tick();
         check("restart_fetch", 32'(core_state), 32'(ST_FETCH));
         run_until(ST_DONE, "restart_done_state");
         check("restart_done", 32'(done), 32'd1);
         check("restart_en", 32'(thread_enable), 32'h3);
         check("restart_bid", 32'(block_id_q), 32'h77);
         check("restart_pc", 32'(current_pc), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
- Per-core control FSM; one instance per compute core.
- Consumes the dispatcher's per-core start/block_id/thread_count and returns done to the dispatcher.
- Sequences each instruction through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for all threads of the block in lockstep.
- Holds the shared program counter and the thread-enable mask.

Parameters:
- THREADS_PER_BLOCK, 4: threads per core (lanes); must match the dispatcher.
- PC_BITS, 8: program counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; the core wrapper drives global reset OR the dispatcher's per-core reset.
- start  in  1  dispatcher core_start; level, held high until done is returned.
- block_id  in  8  block index; latched on start.
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active threads in block; latched on start.
- fetch_valid  in  1  fetcher has instruction for current_pc ready.
- decoded_ret  in  1  decoded instruction is RET; valid from EXECUTE onward.
- lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
- next_pc  in  PC_BITS  next PC from lane 0 ALU/PC unit; valid in UPDATE.
- core_state  out  3  current FSM state, broadcast to fetcher/decoder/ALU/LSU.
- current_pc  out  PC_BITS  shared PC.
- thread_enable  out  THREADS_PER_BLOCK  lane mask, bit i = (i < latched count).
- block_id_q  out  8  latched block id for lane-id generation.
- perf_cycles  out  16  cycle count (see Optional Feature).
- done  out  1  block complete.

Behaviour:
- Reset values: core_state=IDLE(000), current_pc=0, thread_enable=0, block_id_q=0, done=0, perf_cycles=0.
- State encoding: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- IDLE, start=0: remain in IDLE.
- IDLE, start=1:
  - Latch block_id and thread_count.
  - Clamp a count > THREADS_PER_BLOCK to THREADS_PER_BLOCK.
  - Set thread_enable from the clamped count.
  - current_pc <= 0.
  - Go to FETCH; if the clamped count is 0, go to DONE instead.
- FETCH: stay until fetch_valid=1; then go to DECODE next cycle.
- DECODE: exactly 1 cycle, then REQUEST.
- REQUEST: exactly 1 cycle, then WAIT. LSUs sample REQUEST to launch memory ops.
- WAIT:
  - Stay while any enabled lane has lsu_state 01 or 10.
  - Go to EXECUTE when every enabled lane is 00 or 11.
  - Disabled lanes' lsu_state is ignored.
  - The minimum WAIT dwell is 1 cycle, even if all lanes are already idle.
- EXECUTE: exactly 1 cycle, then UPDATE.
- UPDATE:
  - decoded_ret=1: go to DONE; current_pc unchanged.
  - decoded_ret=0: current_pc <= next_pc, go to FETCH.
- PC arithmetic wraps modulo 2^PC_BITS; there is no overflow detection.
- DONE:
  - done=1, registered: it rises in the cycle the state becomes DONE.
  - Remain in DONE regardless of start until reset.
- start deasserted mid-block: ignored; the block runs to DONE.
- Reset mid-operation (any state): return to reset values on the next clock edge; any outstanding LSU responses are discarded by the LSUs' own reset.
- Minimum latency per non-memory instruction: 6 cycles (FETCH with fetch_valid=1 through UPDATE).

Optional Feature:
- Macro: CORE_SCHED_PERF_CYCLES_EN.
- With the macro defined:
  - perf_cycles clears on the IDLE->start transition.
  - It increments by 1 every cycle the state is not IDLE and not DONE.
  - It saturates at 16'hFFFF and holds its value in DONE.
- Without the macro: perf_cycles is tied to 0 and no counter is synthesized.

Test Plan:
- Reset, then start=1, block_id=8'h05, thread_count=4, fetch_valid=1, all lsu_state=00, decoded_ret=1 on the first instruction:
  - Required: state sequence 001,010,011,100,101,110,111.
  - Required: done=1 exactly 7 cycles after start is sampled.
  - Required: block_id_q=5, thread_enable=4'b1111.
- thread_count=3, lane 3 lsu_state=10 held, lanes 0-2 at 00 -> WAIT lasts 1 cycle; thread_enable=4'b0111.
- thread_count=4, lane 1 lsu_state=01 for 2 cycles, then 10 for 3 cycles, then 11 -> WAIT dwell is exactly 5 cycles, then EXECUTE.
- Three instructions with next_pc=1,2 and decoded_ret only on the third, fetch_valid delayed 2 cycles each time:
  - Required: current_pc goes 0->1->2.
  - Required: done after 3 full passes.
  - With CORE_SCHED_PERF_CYCLES_EN: perf_cycles=24.
- thread_count=0 at start -> DONE on the next cycle, thread_enable=0. thread_count=7 with THREADS_PER_BLOCK=4 -> clamped, thread_enable=4'b1111.
- Assert reset while in WAIT with current_pc=3 -> next cycle core_state=000, current_pc=0, done=0, thread_enable=0; a new start then runs normally.
